// File: rtl/aes_avalon_regs_if.sv
// Avalon-MM slave bus bundle for the AES register block.
interface aes_avalon_regs_if;
    logic        AVL_CS;
    logic        AVL_READ;
    logic        AVL_WRITE;
    logic [3:0]  AVL_ADDR;
    logic [3:0]  AVL_BYTE_EN;
    logic [31:0] AVL_WRITEDATA;
    logic [31:0] AVL_READDATA;

    modport master (
        output AVL_CS,
        output AVL_READ,
        output AVL_WRITE,
        output AVL_ADDR,
        output AVL_BYTE_EN,
        output AVL_WRITEDATA,
        input  AVL_READDATA
    );

    modport slave (
        input  AVL_CS,
        input  AVL_READ,
        input  AVL_WRITE,
        input  AVL_ADDR,
        input  AVL_BYTE_EN,
        input  AVL_WRITEDATA,
        output AVL_READDATA
    );
endinterface

// File: rtl/aes_avalon_regs.sv
// Avalon-MM register file fronting an AES core: key/message registers, result capture,
// cycle counter and the start/done handshake FSM.
module aes_avalon_regs #(
    parameter int unsigned EXPORT_ADDR = 0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    aes_avalon_regs_if.slave        avl,
    output logic [31:0]             EXPORT_DATA,
    output logic                    AES_START,
    input  logic                    AES_DONE,
    output logic [127:0]            AES_KEY,
    output logic [127:0]            AES_MSG_ENC,
    input  logic [127:0]            AES_MSG_DEC
);

    localparam logic [3:0] ExportIdx = 4'(EXPORT_ADDR);
    localparam logic [3:0] AddrCycles = 4'd13;
    localparam logic [3:0] AddrStart  = 4'd14;

    typedef enum logic [1:0] {StIdle, StBusy, StComplete, StRelease} state_t;

    state_t      r_state;
    logic        r_aes_start;
    logic        r_done;
    logic        r_start;
    logic [31:0] r_cycles;
    logic [31:0] r_key     [4];
    logic [31:0] r_msg_enc [4];
    logic [31:0] r_msg_dec [4];
    logic [31:0] r_readdata;

    logic        w_wr;
    logic        w_rd;
    logic        w_host_wr_ok;
    logic        w_start_wr;
    logic        w_start_next;
    logic [31:0] w_regfile [16];

    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    assign w_wr         = avl.AVL_CS & avl.AVL_WRITE;
    assign w_rd         = avl.AVL_CS & avl.AVL_READ;
    // Host-writable registers are frozen while the core is working on them.
    assign w_host_wr_ok = (r_state != StBusy);
    assign w_start_wr   = w_wr & w_host_wr_ok & (avl.AVL_ADDR == AddrStart) & avl.AVL_BYTE_EN[0];
    assign w_start_next = w_start_wr ? avl.AVL_WRITEDATA[0] : r_start;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_regfile[i]     = r_key[i];
            w_regfile[i + 4] = r_msg_enc[i];
            w_regfile[i + 8] = r_msg_dec[i];
        end
        w_regfile[12] = 32'd0;
        w_regfile[13] = r_cycles;
        w_regfile[14] = {31'd0, r_start};
        w_regfile[15] = {30'd0, (r_state == StBusy), r_done};
    end

    // Host register writes and registered read data (read sees pre-write contents).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) begin
                r_key[i]     <= 32'd0;
                r_msg_enc[i] <= 32'd0;
            end
            r_start    <= 1'b0;
            r_readdata <= 32'd0;
        end else begin
            if (w_rd) r_readdata <= w_regfile[avl.AVL_ADDR];
            if (w_wr && w_host_wr_ok && !avl.AVL_ADDR[3]) begin
                if (!avl.AVL_ADDR[2]) begin
                    r_key[avl.AVL_ADDR[1:0]] <= f_merge(r_key[avl.AVL_ADDR[1:0]],
                                                        avl.AVL_WRITEDATA, avl.AVL_BYTE_EN);
                end else begin
                    r_msg_enc[avl.AVL_ADDR[1:0]] <= f_merge(r_msg_enc[avl.AVL_ADDR[1:0]],
                                                            avl.AVL_WRITEDATA,
                                                            avl.AVL_BYTE_EN);
                end
            end
            if (w_start_wr) r_start <= avl.AVL_WRITEDATA[0];
        end
    end

    // Control FSM with registered AES_START, DONE flag, cycle counter and result capture.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= StIdle;
            r_aes_start <= 1'b0;
            r_done      <= 1'b0;
            r_cycles    <= 32'd0;
            for (int i = 0; i < 4; i++) r_msg_dec[i] <= 32'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_start_next && !AES_DONE) begin
                        r_state     <= StBusy;
                        r_aes_start <= 1'b1;
                        r_cycles    <= 32'd0;
                    end
                end
                StBusy: begin
                    if (AES_DONE) begin
                        r_state      <= StComplete;
                        r_done       <= 1'b1;
                        r_msg_dec[0] <= AES_MSG_DEC[127:96];
                        r_msg_dec[1] <= AES_MSG_DEC[95:64];
                        r_msg_dec[2] <= AES_MSG_DEC[63:32];
                        r_msg_dec[3] <= AES_MSG_DEC[31:0];
                    end else if (r_cycles != 32'hFFFF_FFFF) begin
                        r_cycles <= r_cycles + 32'd1;
                    end
                end
                StComplete: begin
                    if (w_start_wr && !avl.AVL_WRITEDATA[0]) begin
                        r_state     <= StRelease;
                        r_aes_start <= 1'b0;
                    end
                end
                StRelease: begin
                    if (!AES_DONE) begin
                        r_state <= StIdle;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_aes_start <= 1'b0;
                end
            endcase
        end
    end

    assign avl.AVL_READDATA = r_readdata;
    assign EXPORT_DATA      = w_regfile[ExportIdx];
    assign AES_START        = r_aes_start;
    assign AES_KEY          = {r_key[0], r_key[1], r_key[2], r_key[3]};
    assign AES_MSG_ENC      = {r_msg_enc[0], r_msg_enc[1], r_msg_enc[2], r_msg_enc[3]};

    // Cycle register index kept for readability of the read map above.
    logic w_unused;
    assign w_unused = ^AddrCycles;

endmodule

// File: tb/tb_aes_avalon_regs.sv
// Directed bench for aes_avalon_regs: behavioural model checked every cycle plus literal checks.
module tb_aes_avalon_regs;

    localparam int ExpAddr = 0;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [31:0]  export_data;
    logic         aes_start;
    logic         aes_done = 1'b0;
    logic [127:0] aes_key;
    logic [127:0] aes_msg_enc;
    logic [127:0] aes_msg_dec = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    aes_avalon_regs_if avl ();

    aes_avalon_regs #(.EXPORT_ADDR(ExpAddr)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .avl         (avl),
        .EXPORT_DATA (export_data),
        .AES_START   (aes_start),
        .AES_DONE    (aes_done),
        .AES_KEY     (aes_key),
        .AES_MSG_ENC (aes_msg_enc),
        .AES_MSG_DEC (aes_msg_dec)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_act mirrors "core is being asked to run"; m_done is the sticky completion flag.
    logic [31:0] m_key [4];
    logic [31:0] m_enc [4];
    logic [31:0] m_dec [4];
    logic [31:0] m_cycles, m_rd;
    logic        m_start, m_act, m_done, m_valid = 1'b0;
    logic        m_wr, m_rdq, m_busy, m_wr_ok, m_start_wr, m_start_new;

    assign m_wr        = avl.AVL_CS && avl.AVL_WRITE;
    assign m_rdq       = avl.AVL_CS && avl.AVL_READ;
    assign m_busy      = m_act && !m_done;
    assign m_wr_ok     = m_wr && !m_busy;
    assign m_start_wr  = m_wr_ok && (avl.AVL_ADDR == 4'd14) && avl.AVL_BYTE_EN[0];
    assign m_start_new = m_start_wr ? avl.AVL_WRITEDATA[0] : m_start;

    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (a < 4)       return m_key[a[1:0]];
        else if (a < 8)  return m_enc[a[1:0]];
        else if (a < 12) return m_dec[a[1:0]];
        else if (a == 13) return m_cycles;
        else if (a == 14) return {31'd0, m_start};
        else if (a == 15) return {30'd0, m_busy, m_done};
        return 32'd0;
    endfunction

    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) begin
                m_key[i] <= 0; m_enc[i] <= 0; m_dec[i] <= 0;
            end
            m_cycles <= 0; m_rd <= 0; m_start <= 0; m_act <= 0; m_done <= 0; m_valid <= 1;
        end else begin
            if (m_rdq) m_rd <= m_read(avl.AVL_ADDR);
            if (m_wr_ok && avl.AVL_ADDR < 8) begin
                for (int b = 0; b < 4; b++) begin
                    if (avl.AVL_BYTE_EN[b]) begin
                        if (avl.AVL_ADDR < 4)
                            m_key[avl.AVL_ADDR[1:0]][8*b +: 8] <= avl.AVL_WRITEDATA[8*b +: 8];
                        else
                            m_enc[avl.AVL_ADDR[1:0]][8*b +: 8] <= avl.AVL_WRITEDATA[8*b +: 8];
                    end
                end
            end
            if (m_start_wr) m_start <= avl.AVL_WRITEDATA[0];
            if (!m_act && !m_done) begin
                if (m_start_new && !aes_done) begin
                    m_act <= 1; m_cycles <= 0;
                end
            end else if (m_busy) begin
                if (aes_done) begin
                    m_done <= 1;
                    for (int i = 0; i < 4; i++) m_dec[i] <= aes_msg_dec[127 - 32*i -: 32];
                end else if (m_cycles != 32'hFFFF_FFFF) begin
                    m_cycles <= m_cycles + 1;
                end
            end else if (m_act) begin
                if (m_start_wr && !avl.AVL_WRITEDATA[0]) m_act <= 0;
            end else if (!aes_done) begin
                m_done <= 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            check("aes_start", aes_start, m_act);
            check("aes_key", aes_key, {m_key[0], m_key[1], m_key[2], m_key[3]});
            check("aes_msg_enc", aes_msg_enc, {m_enc[0], m_enc[1], m_enc[2], m_enc[3]});
            check("export_data", export_data, m_read(4'(ExpAddr)));
            check("readdata", avl.AVL_READDATA, m_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        avl.AVL_CS = 1; avl.AVL_WRITE = 1; avl.AVL_ADDR = a;
        avl.AVL_WRITEDATA = d; avl.AVL_BYTE_EN = be;
        step();
        avl.AVL_CS = 0; avl.AVL_WRITE = 0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        avl.AVL_CS = 1; avl.AVL_READ = 1; avl.AVL_ADDR = a;
        step();
        check(name, avl.AVL_READDATA, exp);
        avl.AVL_CS = 0; avl.AVL_READ = 0;
    endtask

    initial begin
        avl.AVL_CS = 0; avl.AVL_READ = 0; avl.AVL_WRITE = 0;
        avl.AVL_ADDR = 0; avl.AVL_BYTE_EN = 0; avl.AVL_WRITEDATA = 0;
        RESET = 1;
        step();
        step();
        RESET = 0;
        check("reset key", aes_key, 128'd0);
        check("reset start", aes_start, 1'b0);
        rd_chk("reset status", 4'd15, 32'd0);

        // Partial byte write.
        wr(4'd4, 32'hFFFF_FFFF, 4'b0101);
        rd_chk("byte enable", 4'd4, 32'h00FF_00FF);

        // Key load.
        wr(4'd0, 32'h2B7E_1516, 4'hF);
        wr(4'd1, 32'h28AE_D2A6, 4'hF);
        wr(4'd2, 32'hABF7_1588, 4'hF);
        wr(4'd3, 32'h09CF_4F3C, 4'hF);
        check("key literal", aes_key, 128'h2B7E151628AED2A6ABF7158809CF4F3C);

        // Simultaneous read and write returns the old value.
        avl.AVL_CS = 1; avl.AVL_READ = 1; avl.AVL_WRITE = 1; avl.AVL_ADDR = 4'd5;
        avl.AVL_WRITEDATA = 32'hCAFE_F00D; avl.AVL_BYTE_EN = 4'hF;
        step();
        check("rd/wr same addr", avl.AVL_READDATA, 32'd0);
        avl.AVL_CS = 0; avl.AVL_READ = 0; avl.AVL_WRITE = 0;
        rd_chk("rd after wr", 4'd5, 32'hCAFE_F00D);
        check("msg_enc literal", aes_msg_enc, {32'h00FF00FF, 32'hCAFEF00D, 64'd0});

        // Read-only and reserved addresses ignore writes.
        wr(4'd8, 32'h1111_1111, 4'hF);
        wr(4'd12, 32'h2222_2222, 4'hF);
        wr(4'd13, 32'h3333_3333, 4'hF);
        wr(4'd15, 32'h3, 4'hF);
        rd_chk("ro reg8", 4'd8, 32'd0);
        rd_chk("reserved", 4'd12, 32'd0);
        rd_chk("ro cycles", 4'd13, 32'd0);
        rd_chk("ro status", 4'd15, 32'd0);

        // Run: 50 cycles with done low (two of them spent on a blocked write and a read).
        wr(4'd14, 32'h1, 4'h1);
        check("start high", aes_start, 1'b1);
        wr(4'd0, 32'h1234_5678, 4'hF);
        rd_chk("key frozen in busy", 4'd0, 32'h2B7E_1516);
        idle(48);
        aes_done = 1;
        aes_msg_dec = 128'hDAEC3055DF058E1C39E814EA76F6747E;
        step();
        check("start in complete", aes_start, 1'b1);
        rd_chk("status done", 4'd15, 32'h1);
        rd_chk("cycles", 4'd13, 32'd50);
        rd_chk("dec0", 4'd8, 32'hDAEC_3055);
        rd_chk("dec1", 4'd9, 32'hDF05_8E1C);
        rd_chk("dec2", 4'd10, 32'h39E8_14EA);
        rd_chk("dec3", 4'd11, 32'h76F6_747E);
        wr(4'd0, 32'h1234_5678, 4'hF);
        rd_chk("key in complete", 4'd0, 32'h1234_5678);

        // Release with done held high for three cycles.
        wr(4'd14, 32'h0, 4'h1);
        check("start drops", aes_start, 1'b0);
        for (int i = 0; i < 3; i++) rd_chk("done held", 4'd15, 32'h1);
        aes_done = 0;
        step();
        rd_chk("status idle", 4'd15, 32'd0);
        rd_chk("dec holds", 4'd8, 32'hDAEC_3055);

        // START written while done is still high waits for done to fall.
        aes_done = 1;
        wr(4'd14, 32'h1, 4'h1);
        idle(2);
        check("start waits", aes_start, 1'b0);
        rd_chk("start reg set", 4'd14, 32'h1);
        aes_done = 0;
        step();
        check("start after done low", aes_start, 1'b1);
        rd_chk("status busy", 4'd15, 32'h2);
        idle(8);
        rd_chk("cycles before abort", 4'd13, 32'd9);

        // Abort with reset mid-run.
        RESET = 1;
        step();
        RESET = 0;
        check("abort start", aes_start, 1'b0);
        for (int i = 0; i < 16; i++) rd_chk("reg after reset", 4'(i), 32'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
